// File: rtl/vga_scanout_if.sv
// -----------------------------------------------------------------------------
// vga_scanout_if
// Avalon-MM register bus between the host (master) and vga_scanout (slave).
//   AVL_READ      master -> slave  read strobe
//   AVL_WRITE     master -> slave  write strobe
//   AVL_CS        master -> slave  chip select, qualifies read and write
//   AVL_ADDR      master -> slave  6-bit word address
//   AVL_WRITEDATA master -> slave  32-bit write data
//   AVL_READDATA  slave -> master  32-bit read data, valid one CLK after a read
// -----------------------------------------------------------------------------
interface vga_scanout_if;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [5:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
// VGA timing generator and palette lookup stage that sits behind the frame
// buffer controller. Produces the scan coordinates, samples the returned colour
// index one pixel later, maps it through a 32 x 24-bit palette and drives the
// DAC/sync pins. Software sees the palette, a status word and a control word.
//
// Ports
//   CLK          system clock (pixel rate is CLK/2)
//   RESET        synchronous, active-low reset
//   avl          Avalon-MM slave (palette 0..31, STATUS 32, CTRL 33)
//   fb_color     palette index returned by the frame buffer
//   fb_drawX/Y   scan coordinates presented to the frame buffer
//   VGA_CLK      pixel clock (equals the internal pixel enable)
//   VGA_HS/VS    active-low syncs, aligned with RGB
//   VGA_BLANK_N  low outside the visible area
//   VGA_R/G/B    pixel colour
//   frame_start  one-CLK pulse when the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic         CLK,
    input  logic         RESET,
    vga_scanout_if.slave avl,
    input  logic [4:0]   fb_color,
    output logic [9:0]   fb_drawX,
    output logic [9:0]   fb_drawY,
    output logic         VGA_CLK,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_BLANK_N,
    output logic [7:0]   VGA_R,
    output logic [7:0]   VGA_G,
    output logic [7:0]   VGA_B,
    output logic         frame_start
);

    // Porch and sync widths are fixed; only the visible/total sizes move.
    localparam logic [9:0] L_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] L_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] L_HS_START   = 10'(H_VISIBLE + 16);
    localparam logic [9:0] L_HS_STOP    = 10'(H_VISIBLE + 16 + 96);
    localparam logic [9:0] L_VS_START   = 10'(V_VISIBLE + 10);
    localparam logic [9:0] L_VS_STOP    = 10'(V_VISIBLE + 12);
    localparam logic [5:0] L_ADDR_STAT  = 6'd32;
    localparam logic [5:0] L_ADDR_CTRL  = 6'd33;

    logic        r_pix_en;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [9:0]  r_draw_x;
    logic [9:0]  r_draw_y;
    logic        r_hs_n;
    logic        r_vs_n;
    logic        r_blank_n;
    logic [23:0] r_rgb;
    logic        r_frame_start;
    logic [15:0] r_frame_count;
    logic        r_enable;
    logic [31:0] r_readdata;
    logic [23:0] r_palette [0:31];

    logic        w_visible;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_in_vblank;
    logic [23:0] w_lookup;
    logic        w_pal_wr;
    logic        w_ctrl_wr;
    logic        w_rd_en;
    logic [31:0] w_rd_data;
    logic        w_unused_wdata;

    // The top byte of a palette write has no storage behind it.
    assign w_unused_wdata = &{1'b0, avl.AVL_WRITEDATA[31:24]};

    // Sync/blank decode and bus strobes. Decoding uses the presented
    // coordinates (one pixel behind the counters) so that the registered
    // result lines up with the RGB of the same pixel.
    always_comb begin
        w_visible   = (r_draw_x < L_H_VIS) && (r_draw_y < L_V_VIS);
        w_hs_n      = !((r_draw_x >= L_HS_START) && (r_draw_x < L_HS_STOP));
        w_vs_n      = !((r_draw_y >= L_VS_START) && (r_draw_y < L_VS_STOP));
        w_in_vblank = (r_draw_y >= L_V_VIS);
        w_lookup    = r_palette[fb_color];
        w_pal_wr    = avl.AVL_CS && avl.AVL_WRITE && (avl.AVL_ADDR[5] == 1'b0);
        w_ctrl_wr   = avl.AVL_CS && avl.AVL_WRITE && (avl.AVL_ADDR == L_ADDR_CTRL);
        w_rd_en     = avl.AVL_CS && avl.AVL_READ;
    end

    // Register-map read multiplexer; unmapped words read as zero.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (avl.AVL_ADDR[5] == 1'b0) begin
            w_rd_data = {8'h00, r_palette[avl.AVL_ADDR[4:0]]};
        end else begin
            case (avl.AVL_ADDR)
                L_ADDR_STAT: w_rd_data = {r_frame_count, 15'h0000, w_in_vblank};
                L_ADDR_CTRL: w_rd_data = {31'h0000_0000, r_enable};
                default:     w_rd_data = 32'h0000_0000;
            endcase
        end
    end

    // Palette storage, deliberately not reset. The lookup reads the array in
    // the same edge, so a colliding write returns the old entry this pixel.
    always_ff @(posedge CLK) begin
        if (RESET && w_pal_wr) begin
            r_palette[avl.AVL_ADDR[4:0]] <= avl.AVL_WRITEDATA[23:0];
        end
    end

    // Pixel enable, counters, coordinate outputs and the registered pixel stage.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_pix_en      <= 1'b0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_hs_n        <= 1'b1;
            r_vs_n        <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                r_draw_x  <= r_h;
                r_draw_y  <= r_v;
                r_hs_n    <= w_hs_n;
                r_vs_n    <= w_vs_n;
                r_blank_n <= w_visible;
                r_rgb     <= (w_visible && r_enable) ? w_lookup : 24'h000000;
                if (r_h == L_H_LAST) begin
                    r_h <= 10'd0;
                    if (r_v == L_V_LAST) begin
                        r_v           <= 10'd0;
                        r_frame_start <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else begin
                        r_v <= r_v + 10'd1;
                    end
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    // Control register and read-data holding register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_enable   <= 1'b0;
            r_readdata <= 32'h0000_0000;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= avl.AVL_WRITEDATA[0];
            end
            if (w_rd_en) begin
                r_readdata <= w_rd_data;
            end
        end
    end

    assign avl.AVL_READDATA = r_readdata;
    assign fb_drawX         = r_draw_x;
    assign fb_drawY         = r_draw_y;
    assign VGA_CLK          = r_pix_en;
    assign VGA_HS           = r_hs_n;
    assign VGA_VS           = r_vs_n;
    assign VGA_BLANK_N      = r_blank_n;
    assign VGA_R            = r_rgb[23:16];
    assign VGA_G            = r_rgb[15:8];
    assign VGA_B            = r_rgb[7:0];
    assign frame_start      = r_frame_start;

endmodule
